// File: rtl/pcpu_muldiv_ctrl.sv
// Iterative 32-step multiply/divide sequencer that owns HI/LO.
// Signed operands are reduced to magnitudes on entry and the result signs are restored in FIX.
module pcpu_muldiv_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_mdStart,
    input  logic [1:0]      id_mdOp,
    input  logic [XLEN-1:0] id_opa,
    input  logic [XLEN-1:0] id_opb,
    input  logic            id_hiloRead,
    input  logic            ex_flush,
    output logic            md_busy,
    output logic            md_stall,
    output logic            md_done,
    output logic            md_divZero,
    output logic [XLEN-1:0] md_hi,
    output logic [XLEN-1:0] md_lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   shf_q, shf_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   opa_raw_q, opa_raw_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic              done_q, done_d;
    logic              dz_q, dz_d;

    logic              op_signed;
    logic              sa, sb;
    logic [XLEN-1:0]   abs_a, abs_b;
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quot_fix, rem_fix;

    assign op_signed = ~id_mdOp[0];
    assign sa        = op_signed & id_opa[XLEN-1];
    assign sb        = op_signed & id_opb[XLEN-1];
    assign abs_a     = sa ? -id_opa : id_opa;
    assign abs_b     = sb ? -id_opb : id_opb;

    // Multiply: {acc, shf} shifts right, adding the multiplicand when the low multiplier bit is set.
    assign mul_sum   = shf_q[0] ? ({1'b0, acc_q} + {1'b0, opb_q}) : {1'b0, acc_q};

    // Divide: acc is the partial remainder, shf shifts dividend bits out and quotient bits in.
    assign div_shift = {acc_q, shf_q[XLEN-1]};
    assign div_ge    = div_shift >= {1'b0, opb_q};
    assign div_diff  = div_shift[XLEN-1:0] - opb_q;

    assign prod      = {acc_q, shf_q};
    assign prod_fix  = neg_res_q ? -prod : prod;
    assign quot_fix  = neg_res_q ? -shf_q : shf_q;
    assign rem_fix   = neg_rem_q ? -acc_q : acc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        acc_d     = acc_q;
        shf_d     = shf_q;
        opb_d     = opb_q;
        opa_raw_d = opa_raw_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = dz_q;

        if (ex_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (id_mdStart) begin
                        is_div_d  = id_mdOp[1];
                        neg_res_d = sa ^ sb;
                        neg_rem_d = sa;
                        acc_d     = '0;
                        shf_d     = abs_a;
                        opb_d     = abs_b;
                        opa_raw_d = id_opa;
                        cnt_d     = '0;
                        dz_d      = id_mdOp[1] & (id_opb == '0);
                        state_d   = S_CALC;
                    end
                end
                S_CALC: begin
                    if (is_div_q) begin
                        acc_d = div_ge ? div_diff : div_shift[XLEN-1:0];
                        shf_d = {shf_q[XLEN-2:0], div_ge};
                    end else begin
                        acc_d = mul_sum[XLEN:1];
                        shf_d = {mul_sum[0], shf_q[XLEN-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    if (!is_div_q) begin
                        hi_d = prod_fix[2*XLEN-1:XLEN];
                        lo_d = prod_fix[XLEN-1:0];
                    end else if (dz_q) begin
                        hi_d = opa_raw_q;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            acc_q     <= '0;
            shf_q     <= '0;
            opb_q     <= '0;
            opa_raw_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            acc_q     <= acc_d;
            shf_q     <= shf_d;
            opb_q     <= opb_d;
            opa_raw_q <= opa_raw_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign md_busy    = (state_q != S_IDLE);
    assign md_stall   = md_busy & (id_mdStart | id_hiloRead);
    assign md_done    = done_q;
    assign md_divZero = dz_q;
    assign md_hi      = hi_q;
    assign md_lo      = lo_q;

endmodule

// File: tb/tb_pcpu_muldiv_ctrl.sv
// Bench for pcpu_muldiv_ctrl: directed and random operations checked against an arithmetic model.
module tb_pcpu_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_mdStart;
    logic [1:0]  id_mdOp;
    logic [31:0] id_opa;
    logic [31:0] id_opb;
    logic        id_hiloRead;
    logic        ex_flush;
    logic        md_busy;
    logic        md_stall;
    logic        md_done;
    logic        md_divZero;
    logic [31:0] md_hi;
    logic [31:0] md_lo;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pcpu_muldiv_ctrl #(.XLEN(32), .CNT_W(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_mdStart (id_mdStart),
        .id_mdOp    (id_mdOp),
        .id_opa     (id_opa),
        .id_opb     (id_opb),
        .id_hiloRead(id_hiloRead),
        .ex_flush   (ex_flush),
        .md_busy    (md_busy),
        .md_stall   (md_stall),
        .md_done    (md_done),
        .md_divZero (md_divZero),
        .md_hi      (md_hi),
        .md_lo      (md_lo)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: MIPS semantics from plain 64-bit arithmetic (truncating division).
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dz);
        longint      sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        dz = op[1] && (b == 32'd0);
        hi = '0;
        lo = '0;
        case (op)
            2'd0: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'd1: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    hi = a;
                    lo = 32'hFFFF_FFFF;
                end else if (op == 2'd2) begin
                    q = sa / sb;
                    r = sa % sb;
                    p = q;
                    lo = p[31:0];
                    p = r;
                    hi = p[31:0];
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Starts an op (caller must be in IDLE, after an edge), checks timing and results.
    // poke_at >= 0 exercises stall/ignored-start at that cycle of CALC.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, input string tag);
        logic [31:0] ehi, elo;
        logic        edz;
        int          bad;
        model(op, a, b, ehi, elo, edz);
        id_mdStart = 1'b1;
        id_mdOp    = op;
        id_opa     = a;
        id_opb     = b;
        #1;
        check({tag, "_idle_stall"}, {31'd0, md_stall}, 32'd0);
        tick();
        id_mdStart = 1'b0;
        id_opa     = $urandom;
        id_opb     = $urandom;
        check({tag, "_dz_at_start"}, {31'd0, md_divZero}, {31'd0, edz});
        bad = 0;
        for (int k = 0; k <= 32; k++) begin
            id_mdStart = 1'b0;
            if (!md_busy || md_done) bad++;
            if (k == poke_at) begin
                id_hiloRead = 1'b1;
                #1;
                check({tag, "_stall_hilo"}, {31'd0, md_stall}, 32'd1);
                id_hiloRead = 1'b0;
                id_mdStart  = 1'b1;
                id_mdOp     = 2'($urandom_range(0, 3));
                #1;
                check({tag, "_stall_start"}, {31'd0, md_stall}, 32'd1);
            end
            tick();
        end
        id_mdStart = 1'b0;
        check({tag, "_busy_window"}, bad, 32'd0);
        check({tag, "_done"}, {31'd0, md_done}, 32'd1);
        check({tag, "_idle_after"}, {31'd0, md_busy}, 32'd0);
        check({tag, "_hi"}, md_hi, ehi);
        check({tag, "_lo"}, md_lo, elo);
        check({tag, "_dz"}, {31'd0, md_divZero}, {31'd0, edz});
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        rst         = 1'b1;
        id_mdStart  = 1'b0;
        id_mdOp     = 2'd0;
        id_opa      = '0;
        id_opb      = '0;
        id_hiloRead = 1'b0;
        ex_flush    = 1'b0;
        #12;
        check("rst_busy", {31'd0, md_busy}, 32'd0);
        check("rst_done", {31'd0, md_done}, 32'd0);
        check("rst_dz", {31'd0, md_divZero}, 32'd0);
        check("rst_hi", md_hi, 32'd0);
        check("rst_lo", md_lo, 32'd0);
        rst = 1'b0;
        tick();

        run_op(2'd1, 32'hFFFF_FFFF, 32'd2, -1, "multu_max");
        check("multu_hi_const", md_hi, 32'h0000_0001);
        check("multu_lo_const", md_lo, 32'hFFFF_FFFE);
        tick();
        check("done_one_cycle", {31'd0, md_done}, 32'd0);

        run_op(2'd0, 32'hFFFF_FFFD, 32'd5, -1, "mult_neg");
        check("mult_neg_lo_const", md_lo, 32'hFFFF_FFF1);
        run_op(2'd0, 32'd7, 32'd6, -1, "mult_b2b");
        check("mult_b2b_lo_const", md_lo, 32'd42);

        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, -1, "div_neg");
        check("div_neg_lo_const", md_lo, 32'hFFFF_FFFD);
        run_op(2'd3, 32'd100, 32'd7, -1, "divu");
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div_ovf");
        check("div_ovf_lo_const", md_lo, 32'h8000_0000);

        run_op(2'd3, 32'h0000_1234, 32'd0, -1, "divu_zero");
        check("divu_zero_hi_const", md_hi, 32'h0000_1234);
        run_op(2'd2, 32'hFFFF_FF00, 32'd0, -1, "div_zero_signed");
        tick();
        ex_flush   = 1'b1;
        id_mdStart = 1'b1;
        id_mdOp    = 2'd1;
        tick();
        ex_flush   = 1'b0;
        id_mdStart = 1'b0;
        check("flush_blocks_start", {31'd0, md_busy}, 32'd0);
        check("flush_keeps_dz", {31'd0, md_divZero}, 32'd1);
        run_op(2'd1, 32'd3, 32'd4, 5, "multu_clr_dz");

        id_hiloRead = 1'b1;
        #1;
        check("idle_hilo_nostall", {31'd0, md_stall}, 32'd0);
        id_hiloRead = 1'b0;

        for (int i = 0; i < 12; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2:    rb = 32'($urandom_range(1, 100));
                3:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, (i % 3 == 0) ? int'($urandom_range(0, 30)) : -1, "rand");
        end

        run_op(2'd3, 32'd59, 32'd6, -1, "set_5_9");
        id_mdStart = 1'b1;
        id_mdOp    = 2'd0;
        id_opa     = 32'h1234_5678;
        id_opb     = 32'h0000_0321;
        tick();
        id_mdStart = 1'b0;
        repeat (9) tick();
        ex_flush = 1'b1;
        tick();
        ex_flush = 1'b0;
        check("flush_idle", {31'd0, md_busy}, 32'd0);
        check("flush_no_done", {31'd0, md_done}, 32'd0);
        check("flush_hi", md_hi, 32'd5);
        check("flush_lo", md_lo, 32'd9);
        tick();
        check("flush_no_done_late", {31'd0, md_done}, 32'd0);

        id_mdStart = 1'b1;
        id_mdOp    = 2'd0;
        tick();
        id_mdStart = 1'b0;
        repeat (19) tick();
        check("pre_rst_busy", {31'd0, md_busy}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, md_busy}, 32'd0);
        check("midrst_done", {31'd0, md_done}, 32'd0);
        check("midrst_hi", md_hi, 32'd0);
        check("midrst_lo", md_lo, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        check("post_rst_busy", {31'd0, md_busy}, 32'd0);
        run_op(2'd2, 32'd1000, 32'hFFFF_FFFD, -1, "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
